// File: rtl/run_controller.sv
// Run sequencer for the 8-bit core: start/ack handshake, core gating,
// RUN-cycle watchdog and host/core arbitration of the data-memory port.
module run_controller #(
    parameter int MAX_CYCLES = 4096,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             core_done,
    input  logic             host_req,
    output logic             ack,
    output logic             timeout,
    output logic             core_run,
    output logic             pc_clear,
    output logic             host_gnt,
    output logic [CNT_W-1:0] cycle_count
);

    typedef enum logic [1:0] {IDLE, ARMED, RUN, FINISH} state_t;

    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(MAX_CYCLES - 1);

    state_t state, next_state;
    logic   arm;

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (start) next_state = ARMED;
            ARMED:   if (!start) next_state = RUN;
            RUN:     if (core_done || cycle_count == LIMIT) next_state = FINISH;
            FINISH:  if (start) next_state = ARMED;
            default: next_state = IDLE;
        endcase
    end

    // Entering ARMED from IDLE or FINISH starts a fresh run record.
    assign arm      = (state != ARMED) && (next_state == ARMED);
    assign core_run = (state == RUN);
    assign pc_clear = (state != RUN);

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            ack         <= 1'b0;
            timeout     <= 1'b0;
            host_gnt    <= 1'b0;
            cycle_count <= '0;
        end else begin
            state    <= next_state;
            ack      <= (next_state == FINISH);
            // Grant is withheld for every RUN cycle, so the core owns the port alone.
            host_gnt <= host_req && (next_state != RUN);
            if (arm) begin
                cycle_count <= '0;
                timeout     <= 1'b0;
            end else if (state == RUN) begin
                cycle_count <= cycle_count + 1'b1;
                if (next_state == FINISH)
                    timeout <= !core_done;
            end
        end
    end

endmodule

// File: tb/tb_run_controller.sv
// Directed bench for run_controller: handshake, watchdog, done/limit tie,
// back-to-back runs, host arbitration and mid-run reset.
module tb_run_controller;

    localparam int MAX_CYCLES = 4096;
    localparam int CNT_W      = 16;

    logic             clk = 1'b0;
    logic             reset, start, core_done, host_req;
    logic             ack, timeout, core_run, pc_clear, host_gnt;
    logic [CNT_W-1:0] cycle_count;

    int n_checks = 0;
    int n_fail   = 0;

    run_controller #(.MAX_CYCLES(MAX_CYCLES), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .start(start), .core_done(core_done),
        .host_req(host_req), .ack(ack), .timeout(timeout), .core_run(core_run),
        .pc_clear(pc_clear), .host_gnt(host_gnt), .cycle_count(cycle_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Inputs change and outputs are sampled on the falling edge.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, ".ack"},      32'(ack),         0);
        chk({tag, ".timeout"},  32'(timeout),     0);
        chk({tag, ".core_run"}, 32'(core_run),    0);
        chk({tag, ".pc_clear"}, 32'(pc_clear),    1);
        chk({tag, ".host_gnt"}, 32'(host_gnt),    0);
        chk({tag, ".count"},    32'(cycle_count), 0);
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; core_done = 1'b0; host_req = 1'b0;
        @(negedge clk);
        step();
        chk_reset_vals("reset");

        // Run 1: start high 3 cycles, done on the 10th RUN cycle
        reset = 1'b0;
        start = 1'b1;
        step(); step(); step();
        chk("armed.core_run", 32'(core_run), 0);
        chk("armed.pc_clear", 32'(pc_clear), 1);
        start = 1'b0;
        step();
        for (int i = 1; i <= 10; i++) begin
            chk("run1.core_run", 32'(core_run), 1);
            chk("run1.pc_clear", 32'(pc_clear), 0);
            chk("run1.count", 32'(cycle_count), 32'(i - 1));
            chk("run1.ack", 32'(ack), 0);
            if (i == 10) core_done = 1'b1;
            step();
        end
        core_done = 1'b0;
        chk("run1.fin.ack", 32'(ack), 1);
        chk("run1.fin.count", 32'(cycle_count), 10);
        chk("run1.fin.timeout", 32'(timeout), 0);
        chk("run1.fin.core_run", 32'(core_run), 0);
        chk("run1.fin.pc_clear", 32'(pc_clear), 1);
        step();
        chk("run1.hold.count", 32'(cycle_count), 10);

        // Back-to-back: start from FINISH, done after 5 cycles
        start = 1'b1;
        step();
        chk("b2b.arm.ack", 32'(ack), 0);
        chk("b2b.arm.count", 32'(cycle_count), 0);
        start = 1'b0;
        step();
        for (int i = 1; i <= 5; i++) begin
            chk("b2b.count", 32'(cycle_count), 32'(i - 1));
            if (i == 5) core_done = 1'b1;
            step();
        end
        core_done = 1'b0;
        chk("b2b.fin.ack", 32'(ack), 1);
        chk("b2b.fin.count", 32'(cycle_count), 5);
        chk("b2b.fin.timeout", 32'(timeout), 0);

        // Watchdog: no done, exactly MAX_CYCLES RUN cycles
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        repeat (MAX_CYCLES - 1) step();
        chk("wd.last.core_run", 32'(core_run), 1);
        chk("wd.last.count", 32'(cycle_count), MAX_CYCLES - 1);
        step();
        chk("wd.ack", 32'(ack), 1);
        chk("wd.timeout", 32'(timeout), 1);
        chk("wd.count", 32'(cycle_count), MAX_CYCLES);
        chk("wd.core_run", 32'(core_run), 0);

        // Done on the limit cycle: done wins; arming clears timeout
        start = 1'b1;
        step();
        chk("tie.arm.timeout", 32'(timeout), 0);
        chk("tie.arm.count", 32'(cycle_count), 0);
        start = 1'b0;
        step();
        repeat (MAX_CYCLES - 1) step();
        chk("tie.pre.count", 32'(cycle_count), MAX_CYCLES - 1);
        core_done = 1'b1;
        step();
        core_done = 1'b0;
        chk("tie.ack", 32'(ack), 1);
        chk("tie.timeout", 32'(timeout), 0);
        chk("tie.count", 32'(cycle_count), MAX_CYCLES);

        // Host arbitration across a full run
        reset = 1'b1;
        step();
        reset = 1'b0;
        host_req = 1'b1;
        step();
        chk("host.idle.gnt", 32'(host_gnt), 1);
        start = 1'b1;
        step();
        chk("host.armed.gnt", 32'(host_gnt), 1);
        start = 1'b0;
        step();
        for (int i = 1; i <= 3; i++) begin
            chk("host.run.gnt", 32'(host_gnt), 0);
            chk("host.run.core_run", 32'(core_run), 1);
            if (i == 3) core_done = 1'b1;
            step();
        end
        core_done = 1'b0;
        chk("host.fin.gnt", 32'(host_gnt), 1);
        chk("host.fin.ack", 32'(ack), 1);
        host_req = 1'b0;

        // Mid-run start pulse ignored, then reset on RUN cycle 7
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        for (int i = 1; i <= 6; i++) begin
            if (i == 3) start = 1'b1;
            if (i == 4) start = 1'b0;
            chk("rst.run.core_run", 32'(core_run), 1);
            chk("rst.run.count", 32'(cycle_count), 32'(i - 1));
            step();
        end
        chk("rst.c7.count", 32'(cycle_count), 6);
        reset = 1'b1;
        step();
        chk_reset_vals("midrst");
        reset = 1'b0;
        step();
        chk("post.core_run", 32'(core_run), 0);
        chk("post.ack", 32'(ack), 0);
        chk("post.pc_clear", 32'(pc_clear), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
